bram_fifo_ctrl: RTL and testbench

Show-ahead FIFO controller that sequences one `bram_2psync` instance as FIFO storage. It accepts a valid/ready write stream and drives the BRAM write port (port B). It drives the BRAM read address (port A) from a read pointer and hides the one-cycle registered-address read latency behind a 3-entry prefetch queue. The result is a valid/ready read stream at one word per cycle. It sits between any producer/consumer pair in the wrapper library that needs a deep buffer.

---
 rtl/bram_fifo_pkg.sv | 16 +
 rtl/fifo_prefetch_q.sv | 54 +++++
 rtl/bram_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_bram_fifo_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared constants and width helpers for the BRAM-backed show-ahead FIFO.
// Optional level/almost_full outputs are enabled with BRAM_FIFO_LEVEL_EN.
package bram_fifo_pkg;

   localparam int unsigned PREFETCH_DEPTH = 3;
   localparam int unsigned OCC_W          = 2;

   function automatic int unsigned ptr_width(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

   function automatic int unsigned level_width(input int unsigned addr_w);
      return addr_w + 2;
   endfunction

endpackage

// File: rtl/fifo_prefetch_q.sv
// Three-entry register queue holding words already read out of the BRAM.
// The head entry drives the FIFO output directly, so m_data is registered.
module fifo_prefetch_q
   import bram_fifo_pkg::*;
#(
   parameter int unsigned DATA = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [DATA-1:0]  push_data,
   input  logic             pop,
   output logic [OCC_W-1:0] occ,
   output logic [DATA-1:0]  head
);

   typedef logic [OCC_W-1:0] idx_t;

   logic [DATA-1:0] mem_q [PREFETCH_DEPTH];
   idx_t            wr_idx_q;
   idx_t            rd_idx_q;
   idx_t            occ_q;
   logic            pop_ok;

   function automatic idx_t idx_inc(input idx_t idx);
      return (idx == idx_t'(PREFETCH_DEPTH - 1)) ? '0 : idx + idx_t'(1);
   endfunction

   assign pop_ok = pop && (occ_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PREFETCH_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_idx_q] <= push_data;
            wr_idx_q        <= idx_inc(wr_idx_q);
         end
         if (pop_ok) begin
            rd_idx_q <= idx_inc(rd_idx_q);
         end
         occ_q <= occ_q + idx_t'(push) - idx_t'(pop_ok);
      end
   end

   assign occ  = occ_q;
   assign head = mem_q[rd_idx_q];

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Show-ahead FIFO controller sequencing an external two-port BRAM as storage.
// Define BRAM_FIFO_LEVEL_EN to add the registered level and almost_full outputs.
module bram_fifo_ctrl
   import bram_fifo_pkg::*;
#(
   parameter int unsigned DATA      = 8,
   parameter int unsigned ADDR      = 6,
   parameter int unsigned AF_THRESH = 2 ** ADDR
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA-1:0]               s_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA-1:0]               m_data,
   output logic                          ram_we,
   output logic [ADDR-1:0]               ram_waddr,
   output logic [DATA-1:0]               ram_wdata,
   output logic [ADDR-1:0]               ram_raddr,
   input  logic [DATA-1:0]               ram_rdata
`ifdef BRAM_FIFO_LEVEL_EN
   ,
   output logic [level_width(ADDR)-1:0] level,
   output logic                          almost_full
`endif
);

   localparam int unsigned PW = ptr_width(ADDR);
   localparam int unsigned LW = level_width(ADDR);

   typedef logic [PW-1:0] ptr_t;

   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   ptr_t             ram_cnt, ram_cnt_d;
   logic             s_ready_q;
   logic             inflight_q, inflight_d;
   logic             accept, fetch, pop;
   logic [OCC_W-1:0] occ;

   assign ram_cnt = wr_ptr_q - rd_ptr_q;
   assign accept  = s_valid & s_ready_q;
   assign pop     = m_valid & m_ready;
   // Issue only when the fetched word is guaranteed a free prefetch slot.
   assign fetch   = (ram_cnt != '0) &&
                    ((32'(occ) + 32'(inflight_q)) < PREFETCH_DEPTH);

   always_comb begin
      wr_ptr_d   = wr_ptr_q + ptr_t'(accept);
      rd_ptr_d   = rd_ptr_q + ptr_t'(fetch);
      ram_cnt_d  = wr_ptr_d - rd_ptr_d;
      inflight_d = fetch;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
         s_ready_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         inflight_q <= inflight_d;
         // MSB of the occupancy is set only when the RAM holds 2**ADDR words.
         s_ready_q  <= ~ram_cnt_d[ADDR];
      end
   end

   fifo_prefetch_q #(
      .DATA (DATA)
   ) u_prefetch_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (ram_rdata),
      .pop       (pop),
      .occ       (occ),
      .head      (m_data)
   );

   assign s_ready   = s_ready_q;
   assign m_valid   = (occ != '0);
   assign ram_we    = accept;
   assign ram_waddr = wr_ptr_q[ADDR-1:0];
   assign ram_wdata = s_data;
   assign ram_raddr = rd_ptr_q[ADDR-1:0];

`ifdef BRAM_FIFO_LEVEL_EN
   logic [OCC_W-1:0] occ_d;
   logic [LW-1:0]    level_q, level_d;
   logic             almost_full_q;

   assign occ_d   = occ + OCC_W'(inflight_q) - OCC_W'(pop);
   assign level_d = LW'(ram_cnt_d) + LW'(inflight_d) + LW'(occ_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q       <= '0;
         almost_full_q <= 1'b0;
      end else begin
         level_q       <= level_d;
         almost_full_q <= (32'(level_d) >= AF_THRESH);
      end
   end

   assign level       = level_q;
   assign almost_full = almost_full_q;
`else
   logic unused_af_thresh;
   assign unused_af_thresh = (AF_THRESH != 0);
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with a behavioural BRAM and a scoreboard queue.
// Level/almost_full checks are compiled in when BRAM_FIFO_LEVEL_EN is defined.
module tb_bram_fifo_ctrl;

   localparam int unsigned DATA = 8;
   localparam int unsigned ADDR = 6;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [DATA-1:0] s_data = '0;
   logic            m_valid;
   logic            m_ready = 1'b0;
   logic [DATA-1:0] m_data;
   logic            ram_we;
   logic [ADDR-1:0] ram_waddr;
   logic [DATA-1:0] ram_wdata;
   logic [ADDR-1:0] ram_raddr;
   logic [DATA-1:0] ram_rdata;
`ifdef BRAM_FIFO_LEVEL_EN
   logic [ADDR+1:0] level;
   logic            almost_full;
`endif

   always #5 clk = ~clk;

   bram_fifo_ctrl #(
      .DATA      (DATA),
      .ADDR      (ADDR),
      .AF_THRESH (2 ** ADDR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .ram_we      (ram_we),
      .ram_waddr   (ram_waddr),
      .ram_wdata   (ram_wdata),
      .ram_raddr   (ram_raddr),
      .ram_rdata   (ram_rdata)
`ifdef BRAM_FIFO_LEVEL_EN
      ,
      .level       (level),
      .almost_full (almost_full)
`endif
   );

   // Registered-address BRAM: read data is mem[address presented last cycle].
   logic [DATA-1:0] bram [2 ** ADDR];
   logic [ADDR-1:0] bram_addr_q;
   always @(posedge clk) begin
      if (ram_we) bram[ram_waddr] <= ram_wdata;
      bram_addr_q <= ram_raddr;
   end
   assign ram_rdata = bram[bram_addr_q];

   int unsigned     checks = 0;
   int unsigned     passed = 0;
   logic [DATA-1:0] sb [$];
   int              cyc = 0;
   int              n_pop = 0;
   int              n_acc = 0;
   logic            last_acc, last_pop;

   typedef struct packed {
      logic            sv;
      logic [DATA-1:0] sd;
      logic            mr;
      logic            e_sr;
      logic            e_mv;
      logic            e_we;
      logic            chk_d;
      logic [DATA-1:0] e_md;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // One clock: scoreboard bookkeeping at the negedge, then the active edge.
   task automatic tick();
      @(negedge clk);
      last_acc = s_valid && s_ready;
      last_pop = m_valid && m_ready;
      if (last_pop) begin
         n_pop++;
         if (sb.size() == 0) check("pop_with_empty_scoreboard", 32'(m_data), 32'hFFFF_FFFF);
         else check("pop_data", 32'(m_data), 32'(sb.pop_front()));
      end
      if (last_acc) begin
         n_acc++;
         sb.push_back(s_data);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input string name);
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 200 && (sb.size() != 0 || m_valid); i++) tick();
      check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
      check({name, "_m_valid_low"}, 32'(m_valid), 32'd0);
      m_ready = 1'b0;
   endtask

   initial begin
      int first_acc, last_acc_c, first_pop, last_pop_c, pop0, acc0;

      vecs[0]  = '{sv: 1'b0, sd: 8'h00, mr: 1'b0, e_sr: 1'b0, e_mv: 1'b0, e_we: 1'b0, chk_d: 1'b1, e_md: 8'h00};
      vecs[1]  = '{sv: 1'b1, sd: 8'hA5, mr: 1'b0, e_sr: 1'b1, e_mv: 1'b0, e_we: 1'b1, chk_d: 1'b0, e_md: 8'h00};
      vecs[2]  = '{sv: 1'b0, sd: 8'h00, mr: 1'b0, e_sr: 1'b1, e_mv: 1'b0, e_we: 1'b0, chk_d: 1'b0, e_md: 8'h00};
      vecs[3]  = '{sv: 1'b0, sd: 8'h00, mr: 1'b0, e_sr: 1'b1, e_mv: 1'b0, e_we: 1'b0, chk_d: 1'b0, e_md: 8'h00};
      vecs[4]  = '{sv: 1'b0, sd: 8'h00, mr: 1'b1, e_sr: 1'b1, e_mv: 1'b1, e_we: 1'b0, chk_d: 1'b1, e_md: 8'hA5};
      vecs[5]  = '{sv: 1'b1, sd: 8'h3C, mr: 1'b0, e_sr: 1'b1, e_mv: 1'b0, e_we: 1'b1, chk_d: 1'b0, e_md: 8'h00};
      vecs[6]  = '{sv: 1'b1, sd: 8'hC3, mr: 1'b0, e_sr: 1'b1, e_mv: 1'b0, e_we: 1'b1, chk_d: 1'b0, e_md: 8'h00};
      vecs[7]  = '{sv: 1'b0, sd: 8'h00, mr: 1'b0, e_sr: 1'b1, e_mv: 1'b0, e_we: 1'b0, chk_d: 1'b0, e_md: 8'h00};
      vecs[8]  = '{sv: 1'b0, sd: 8'h00, mr: 1'b1, e_sr: 1'b1, e_mv: 1'b1, e_we: 1'b0, chk_d: 1'b1, e_md: 8'h3C};
      vecs[9]  = '{sv: 1'b0, sd: 8'h00, mr: 1'b1, e_sr: 1'b1, e_mv: 1'b1, e_we: 1'b0, chk_d: 1'b1, e_md: 8'hC3};
      vecs[10] = '{sv: 1'b0, sd: 8'h00, mr: 1'b0, e_sr: 1'b1, e_mv: 1'b0, e_we: 1'b0, chk_d: 1'b0, e_md: 8'h00};

      // Reset held: outputs at reset values.
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      rst_n = 1'b1;

      // Vector table: single word 0xA5, then two back-to-back words.
      for (int i = 0; i < 11; i++) begin
         s_valid = vecs[i].sv;
         s_data  = vecs[i].sd;
         m_ready = vecs[i].mr;
         #1;
         check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
         check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
         check($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
         if (vecs[i].chk_d) check($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_md));
         tick();
      end
`ifdef BRAM_FIFO_LEVEL_EN
      check("single_level_zero", 32'(level), 32'd0);
`endif

      // Fill with the consumer stalled: 64 RAM words + 3 prefetched.
      m_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 100; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i + 8'h10);
         tick();
      end
      s_valid = 1'b0;
      #1;
      check("fill_accepted", 32'(n_acc - acc0), 32'd67);
      check("fill_s_ready_low", 32'(s_ready), 32'd0);
      check("fill_m_valid", 32'(m_valid), 32'd1);
      check("fill_head", 32'(m_data), 32'h10);
`ifdef BRAM_FIFO_LEVEL_EN
      check("fill_level", 32'(level), 32'd67);
      check("fill_almost_full", 32'(almost_full), 32'd1);
`endif
      drain("fill_drain");

      // Streaming: 200 words, both sides always ready, pointers wrap.
      acc0 = n_acc;
      pop0 = n_pop;
      first_acc = -1; last_acc_c = -1; first_pop = -1; last_pop_c = -1;
      m_ready = 1'b1;
      for (int c = 0; c < 400 && (n_pop - pop0) < 200; c++) begin
         s_valid = ((n_acc - acc0) < 200);
         s_data  = 8'((n_acc - acc0) * 7 + 1);
         tick();
         if (last_acc) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc_c = cyc;
         end
         if (last_pop) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop_c = cyc;
         end
      end
      check("stream_pops", 32'(n_pop - pop0), 32'd200);
      check("stream_write_span", 32'(last_acc_c - first_acc), 32'd199);
      check("stream_read_span", 32'(last_pop_c - first_pop), 32'd199);
      check("stream_startup", 32'(first_pop - first_acc), 32'd3);
      drain("stream_drain");

      // Random backpressure on both sides.
      for (int c = 0; c < 10000; c++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = 8'($urandom);
         m_ready = ($urandom_range(0, 1) != 0);
         tick();
`ifdef BRAM_FIFO_LEVEL_EN
         if (level > 67) check("rand_level_bound", 32'(level), 32'd67);
`endif
      end
      drain("rand_drain");

      // Reset in the middle of a transfer with 20 words held.
      m_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h80 + i);
         tick();
      end
`ifdef BRAM_FIFO_LEVEL_EN
      check("pre_reset_level", 32'(level), 32'd20);
`endif
      rst_n = 1'b0;
      #1;
      check("midrst_s_ready", 32'(s_ready), 32'd0);
      check("midrst_m_valid", 32'(m_valid), 32'd0);
      check("midrst_m_data", 32'(m_data), 32'd0);
      check("midrst_ram_we", 32'(ram_we), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_almost_full", 32'(almost_full), 32'd0);
`endif
      sb.delete();
      s_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("release_s_ready_before_edge", 32'(s_ready), 32'd0);
      tick();
      check("release_s_ready_after_edge", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = 8'h5A;
      tick();
      s_valid = 1'b0;
      m_ready = 1'b1;
      pop0 = n_pop;
      for (int i = 0; i < 10 && n_pop == pop0; i++) tick();
      check("post_reset_first_word_popped", 32'(n_pop - pop0), 32'd1);
      drain("final_drain");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
